fifo_rr_arbiter: RTL and testbench
==================================

Name: fifo_rr_arbiter

Overview:
Round-robin arbiter that shares one valid/ready stream sink, normally the write side of a FIFO, between NUM_REQ requesters.
- A requester holds its grant for a burst of up to BURST_LEN beats, then the grant rotates.
- Sits between producer blocks and the FIFO write port (data_in_i / data_in_valid_i / data_in_ready_o).
- Purely a sequencer: it stores no payload.

Parameters:
NUM_REQ, 4, number of requesters, >= 2.
DATA_WIDTH, 8, payload width, must match the FIFO.
BURST_LEN, 4, max handshakes per grant, >= 1.

Ports:
clk_i  input  1  clock, rising edge.
arst_ni  input  1  reset, asynchronous, active-low.
req_data_i  input  NUM_REQ*DATA_WIDTH  packed payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
req_valid_i  input  NUM_REQ  per-requester valid.
req_ready_o  output  NUM_REQ  per-requester ready.
data_out_o  output  DATA_WIDTH  payload to sink.
data_out_valid_o  output  1  valid to sink.
data_out_ready_i  input  1  ready from sink (FIFO data_in_ready_o).
grant_id_o  output  $clog2(NUM_REQ)  index of the current owner.
busy_o  output  1  high while in GRANT.

Behaviour:
- Clock and reset: one clock, clk_i. arst_ni is asynchronous assert, active-low. All flops reset on arst_ni low.
- Reset values:
  - state = IDLE, last_grant = NUM_REQ-1 (so requester 0 has first priority), beat_cnt = 0, grant_id = 0.
  - Outputs: data_out_valid_o=0, req_ready_o=0, data_out_o=0, grant_id_o=0, busy_o=0.
- States: IDLE, GRANT.
- IDLE:
  - All req_ready_o=0, data_out_valid_o=0, data_out_o=0.
  - If any req_valid_i is high, the winner is the first asserted index searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Winner is registered into grant_id. Next state is GRANT and beat_cnt is cleared.
  - Arbitration latency is one cycle: a valid asserted in cycle t gives data_out_valid_o at t+1 at the earliest.
- GRANT (owner g = grant_id):
  - data_out_o = req_data_i[g] and data_out_valid_o = req_valid_i[g], both combinational.
  - req_ready_o[g] = data_out_ready_i; all other ready bits are 0.
  - Handshake = req_valid_i[g] & data_out_ready_i.
  - On a handshake: if beat_cnt == BURST_LEN-1, release; otherwise beat_cnt increments.
  - Release if req_valid_i[g] is low in any GRANT cycle (owner finished early); no beat is counted that cycle.
  - Release means: last_grant <= g, beat_cnt <= 0, state <= IDLE next cycle.
  - Result: one bubble cycle between grants; throughput is BURST_LEN/(BURST_LEN+1) under full contention.
- Backpressure: while data_out_ready_i=0, the grant is held indefinitely and beat_cnt is frozen. Owner valid must stay high, per the stream rule.
- Protocol note: a requester dropping valid without a handshake is an upstream violation. The arbiter still releases and does not lose state.
- Fairness:
  - A requester re-requesting immediately after release is served only after every other active requester.
  - No starvation: worst-case wait is (NUM_REQ-1)*(BURST_LEN+1) grant-cycles, excluding sink stalls.
- Widths: beat_cnt is $clog2(BURST_LEN+1) bits. Index wrap uses an explicit compare against NUM_REQ-1, which also covers non-power-of-2 NUM_REQ.
- Reset mid-burst: everything returns to reset values immediately and asynchronously. Any partially transferred burst is abandoned.
- busy_o = (state == GRANT). grant_id_o is valid whenever busy_o=1 and holds its last value in IDLE.

Decomposition:
- Package fifo_arb_pkg:
  - arb_state_e enum {IDLE, GRANT}.
  - Helper function clog2_min1 (returns >= 1 for index widths).
- Sub-module rr_priority_picker: combinational, with inputs req vector and last_grant, outputs a winner index and any_req. Parameterised by NUM_REQ.
- Top level holds the state machine, counters and mux.

Test Plan:
- Reset, then req_valid_i=0001 with continuous data 0x10..0x15 and sink always ready, BURST_LEN=4:
  - 0x10..0x13 accepted on 4 consecutive cycles after 1 idle cycle.
  - 1 bubble cycle, then 0x14, 0x15 accepted; grant_id_o=0 throughout.
- All four requesters valid continuously, sink ready: grant order 0,1,2,3,0; each grant exactly 4 beats; exactly 1 bubble between grants.
- Requester 2 alone, data_out_ready_i low for 5 cycles mid-burst after beat 2:
  - data_out_valid_o stays high and the grant is held.
  - beat_cnt stays 2, and exactly 2 more beats follow once ready returns.
- Requester 1 valid for 2 beats then drops, requester 3 waiting: release after 2 beats, idle cycle, then grant_id_o=3.
- arst_ni pulsed low during beat 3 of a grant to requester 1:
  - All outputs zero within the reset cycle.
  - After reset, with requesters 1 and 3 valid, requester 1 wins (last_grant reset to 3).
- Connected to a 16-entry FIFO with its read side stalled, two requesters:
  - Exactly 16 beats accepted, then data_out_ready_i=0 holds the grant.
  - No data loss or duplication; the FIFO's output order matches the grant order.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Imported by the priority picker and the arbiter top level.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width that never collapses to zero bits, even for degenerate counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request strictly after
// last_grant_i, wrapping at NUM_REQ-1 (works for non-power-of-2 counts).
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_req_o
);

    logic [IDX_W-1:0] idx;

    // NOTE: every variable written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        winner_o  = '0;
        any_req_o = 1'b0;
        idx       = last_grant_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
            if (!any_req_o && req_i[idx]) begin
                any_req_o = 1'b1;
                winner_o  = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready sink between NUM_REQ producers.
// Grants last up to BURST_LEN handshakes, with one idle cycle between grants.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                             clk_i,
    input  logic                             arst_ni,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic [DATA_WIDTH-1:0]            data_out_o,
    output logic                             data_out_valid_o,
    input  logic                             data_out_ready_i,
    output logic [clog2_min1(NUM_REQ)-1:0]   grant_id_o,
    output logic                             busy_o
);

    localparam int IDX_W = clog2_min1(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [IDX_W-1:0]      winner;
    logic                  any_req;
    logic                  owner_valid;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  release_grant;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .any_req_o    (any_req)
    );

    // Select the current owner's lane; compares avoid out-of-range part-selects.
    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id_q == IDX_W'(k)) begin
                owner_valid = req_valid_i[k];
                owner_data  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        grant_id_d       = grant_id_q;
        beat_cnt_d       = beat_cnt_q;
        release_grant    = 1'b0;
        req_ready_o      = '0;
        data_out_o       = '0;
        data_out_valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_id_d = winner;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                data_out_valid_o = owner_valid;
                data_out_o       = owner_data;
                for (int k = 0; k < NUM_REQ; k++) begin
                    req_ready_o[k] = (grant_id_q == IDX_W'(k)) & data_out_ready_i;
                end
                // An owner dropping valid ends its burst early; a stalled sink freezes it.
                if (!owner_valid) begin
                    release_grant = 1'b1;
                end else if (data_out_ready_i) begin
                    if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        release_grant = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
                if (release_grant) begin
                    last_grant_d = grant_id_q;
                    beat_cnt_d   = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign busy_o     = (state_q == GRANT);
    assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter: a transaction-level arbitration model
// predicts per-cycle outputs and accepted beats; a monitor compares them.
module tb_fifo_rr_arbiter;

    localparam int N          = 4;
    localparam int DW         = 8;
    localparam int BL         = 4;
    localparam int FIFO_DEPTH = 16;

    logic            clk_i = 1'b0;
    logic            arst_ni;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [DW-1:0]   data_out_o;
    logic            data_out_valid_o;
    logic            data_out_ready_i;
    logic [1:0]      grant_id_o;
    logic            busy_o;

    always #5 clk_i = ~clk_i;

    fifo_rr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk_i            (clk_i),
        .arst_ni          (arst_ni),
        .req_data_i       (req_data_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .data_out_o       (data_out_o),
        .data_out_valid_o (data_out_valid_o),
        .data_out_ready_i (data_out_ready_i),
        .grant_id_o       (grant_id_o),
        .busy_o           (busy_o)
    );

    typedef struct packed {
        logic          busy;
        logic          valid;
        logic [N-1:0]  ready;
        logic [DW-1:0] data;
        logic [1:0]    gid;
    } cyc_t;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } beat_t;

    int n_checks = 0;
    int n_fail   = 0;

    cyc_t  cyc_q[$];
    beat_t beat_q[$];

    logic [DW-1:0] pq [N][$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_fifo[$];
    int            beats_seen[N];
    logic          ready_val = 1'b1;
    bit            fifo_mode = 1'b0;
    logic [DW-1:0] next_val  = 8'h40;

    // Reference model: who owns the sink, how many beats it has moved, who went last.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = N - 1;
    int m_gid   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid_i[k]        = (pq[k].size() > 0);
            req_data_i[k*DW +: DW] = (pq[k].size() > 0) ? pq[k][0] : '0;
        end
        data_out_ready_i = fifo_mode ? (fifo_q.size() < FIFO_DEPTH) : ready_val;
    endtask

    task automatic step();
        cyc_t          e;
        logic [N-1:0]  dut_rdy;
        logic          dut_out_hs;
        logic [DW-1:0] dut_data;
        logic [DW-1:0] od;
        int            g;
        @(negedge clk_i);
        e = '0;
        if (!arst_ni) begin
            m_owner = -1;
            m_beats = 0;
            m_last  = N - 1;
            m_gid   = 0;
        end else if (m_owner < 0) begin
            e.gid = m_gid[1:0];
            for (int i = 1; i <= N; i++) begin
                if (m_owner < 0 && req_valid_i[(m_last + i) % N]) begin
                    m_owner = (m_last + i) % N;
                    m_gid   = m_owner;
                    m_beats = 0;
                end
            end
        end else begin
            g       = m_owner;
            od      = req_data_i[g*DW +: DW];
            e.busy  = 1'b1;
            e.valid = req_valid_i[g];
            e.data  = od;
            e.ready = data_out_ready_i ? N'(1 << g) : '0;
            e.gid   = g[1:0];
            if (!req_valid_i[g]) begin
                m_last  = g;
                m_owner = -1;
            end else if (data_out_ready_i) begin
                beat_q.push_back('{id: g[1:0], data: od});
                if (fifo_mode) exp_fifo.push_back(od);
                m_beats++;
                if (m_beats == BL) begin
                    m_last  = g;
                    m_owner = -1;
                    m_beats = 0;
                end
            end
        end
        cyc_q.push_back(e);
        dut_rdy    = req_ready_o;
        dut_out_hs = data_out_valid_o & data_out_ready_i;
        dut_data   = data_out_o;
        @(posedge clk_i);
        #1;
        for (int k = 0; k < N; k++) begin
            if (req_valid_i[k] && dut_rdy[k]) begin
                void'(pq[k].pop_front());
                beats_seen[k]++;
            end
        end
        if (fifo_mode && dut_out_hs) fifo_q.push_back(dut_data);
        drive();
    endtask

    function automatic bit pending();
        for (int k = 0; k < N; k++) begin
            if (pq[k].size() > 0) return 1'b1;
        end
        return (m_owner >= 0);
    endfunction

    task automatic drain(input string name, input int max_cycles);
        int n = 0;
        while (pending() && n < max_cycles) begin
            step();
            n++;
        end
        check({name, "_drained"}, 64'(pending()), 64'd0);
    endtask

    task automatic clear_seen();
        for (int k = 0; k < N; k++) beats_seen[k] = 0;
    endtask

    // Monitor: compares the predicted cycle and any accepted beat.
    initial begin
        cyc_t  e;
        beat_t b;
        forever begin
            @(negedge clk_i);
            #1;
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                check("cycle{busy,valid,ready,data,gid}",
                      {busy_o, data_out_valid_o, req_ready_o, data_out_o, grant_id_o}, e);
            end
            if (data_out_valid_o && data_out_ready_i) begin
                if (beat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat: unexpected handshake id %0d data %0h, none expected",
                             grant_id_o, data_out_o);
                end else begin
                    b = beat_q.pop_front();
                    check("beat{id,data}", {grant_id_o, data_out_o}, b);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        arst_ni = 1'b0;
        clear_seen();
        drive();
        repeat (3) step();
        arst_ni = 1'b1;
        drive();

        // Single requester, 6 beats: burst of 4, bubble, then 2.
        for (int i = 0; i < 6; i++) pq[0].push_back(8'h10 + DW'(i));
        drive();
        drain("solo_req0", 40);

        // Full contention: rotation with exactly one bubble between grants.
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 8; i++) begin
                pq[k].push_back(next_val);
                next_val++;
            end
        end
        drive();
        drain("contention", 100);

        // Sink stall mid-burst after beat 2 of requester 2.
        clear_seen();
        for (int i = 0; i < 6; i++) begin
            pq[2].push_back(next_val);
            next_val++;
        end
        drive();
        n = 0;
        while (beats_seen[2] < 2 && n < 20) begin
            step();
            n++;
        end
        check("stall_reached_beat2", 64'(beats_seen[2]), 64'd2);
        ready_val = 1'b0;
        drive();
        repeat (5) step();
        check("stall_held_busy", 64'(busy_o), 64'd1);
        ready_val = 1'b1;
        drive();
        drain("stall", 40);
        check("stall_total_beats", 64'(beats_seen[2]), 64'd6);

        // Early release: requester 1 has only 2 beats, requester 3 waits.
        for (int i = 0; i < 2; i++) begin
            pq[1].push_back(next_val);
            next_val++;
        end
        drive();
        repeat (2) step();
        for (int i = 0; i < 3; i++) begin
            pq[3].push_back(next_val);
            next_val++;
        end
        drive();
        drain("early_release", 40);

        // Asynchronous reset during beat 3 of a grant to requester 1.
        clear_seen();
        for (int i = 0; i < 6; i++) begin
            pq[1].push_back(next_val);
            next_val++;
        end
        drive();
        n = 0;
        while (beats_seen[1] < 2 && n < 20) begin
            step();
            n++;
        end
        arst_ni = 1'b0;
        #1;
        check("async_reset_outputs",
              {busy_o, data_out_valid_o, req_ready_o, data_out_o, grant_id_o}, 64'd0);
        repeat (2) step();
        arst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pq[3].push_back(next_val);
            next_val++;
        end
        drive();
        step();
        check("post_reset_winner_is_1", {busy_o, grant_id_o}, {1'b1, 2'd1});
        drain("post_reset", 60);

        // 16-entry FIFO sink with its read side stalled.
        fifo_q.delete();
        exp_fifo.delete();
        for (int i = 0; i < 12; i++) begin
            pq[0].push_back(next_val);
            next_val++;
            pq[2].push_back(next_val);
            next_val++;
        end
        fifo_mode = 1'b1;
        drive();
        repeat (45) step();
        check("fifo_filled_count", 64'(fifo_q.size()), 64'd16);
        check("fifo_full_grant_held", {busy_o, data_out_valid_o}, 2'b11);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (i < fifo_q.size() && i < exp_fifo.size())
                check("fifo_order", 64'(fifo_q[i]), 64'(exp_fifo[i]));
        end
        fifo_mode = 1'b0;
        ready_val = 1'b1;
        drive();
        drain("fifo_release", 80);

        // Randomized arrivals and sink backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (pq[k].size() < 3 && $urandom_range(0, 3) == 0) begin
                    pq[k].push_back(next_val);
                    next_val++;
                end
            end
            ready_val = ($urandom_range(0, 3) != 0);
            drive();
            step();
        end
        ready_val = 1'b1;
        drive();
        drain("random", 200);
        step();
        check("leftover_beats", 64'(beat_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
